// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Drain side for the show-ahead sync FIFO. Words are popped through the FIFO's
// rd_en/empty/dout interface and presented downstream as a registered
// valid/ready stream. A two-entry skid buffer (main + skid) keeps one word per
// cycle flowing under backpressure while fifo_rd_en depends only on registered
// state, fifo_empty, flush and rst_b (never on m_ready). The stream is framed
// into bursts of BURST_LEN beats, with m_last marking the final beat.
//
// Parameters:
//   DSIZE      data word width, must match the FIFO
//   BURST_LEN  accepted beats per burst (>= 1)
//
// Ports:
//   clk          clock
//   rst_b        asynchronous active-low reset
//   fifo_dout    FIFO head word, valid whenever fifo_empty = 0
//   fifo_empty   FIFO empty flag
//   fifo_rd_en   pop strobe, FIFO advances on the clk edge where it is 1
//   flush        synchronous clear of held words and beat counter
//   m_data       stream data (registered)
//   m_valid      stream valid (registered)
//   m_ready      downstream ready
//   m_last       last beat of the current burst
//   stall_cycles saturating count of cycles with m_valid & ~m_ready
//
// Optional build macro:
//   FIFO_READER_STATS_EN  builds the stall_cycles counter; when undefined the
//                         port is tied to zero and no counter exists.
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [DSIZE-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic             flush,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [15:0]      stall_cycles
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  // State encodes how many words are currently held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DSIZE-1:0] main_q, main_d;
  logic [DSIZE-1:0] skid_q, skid_d;
  logic [CW-1:0]    beat_q, beat_d;

  logic pop;
  logic accept;

  // The pop strobe deliberately excludes m_ready: when both entries are full
  // the FIFO is simply not read, so there is no ready-to-rd_en timing path.
  // rst_b is folded in so the strobe drops the instant reset asserts.
  assign fifo_rd_en = rst_b & ~fifo_empty & ~flush & (state_q != TWO);
  assign pop        = fifo_rd_en;
  assign accept     = m_valid & m_ready;

  assign m_valid = (state_q != EMPTY);
  assign m_data  = main_q;
  assign m_last  = m_valid & (beat_q == LAST_BEAT);

  // Next-state logic. Flush wins over everything; an accept in the flush
  // cycle still completes downstream but is not counted as a beat.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    beat_d  = beat_q;

    if (flush) begin
      state_d = EMPTY;
      beat_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (pop) begin
            main_d  = fifo_dout;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = fifo_dout;
          end else if (accept) begin
            state_d = EMPTY;
          end else if (pop) begin
            // Word popped while downstream stalls: park it behind main.
            skid_d  = fifo_dout;
            state_d = TWO;
          end
        end
        TWO: begin
          if (accept) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase

      if (accept) begin
        beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + CW'(1);
      end
    end
  end

  // Holding registers and beat counter.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      beat_q  <= beat_d;
    end
  end

`ifdef FIFO_READER_STATS_EN
  logic [15:0] stall_q, stall_d;

  // Saturating backpressure counter, cleared by flush.
  always_comb begin
    stall_d = stall_q;
    if (flush) begin
      stall_d = '0;
    end else if (m_valid && !m_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Drives fifo_stream_reader from a behavioural show-ahead FIFO held in a queue.
// Every word pushed into the FIFO is also pushed into an expected-word queue;
// each downstream accept pops and compares it. A small beat counter model
// predicts m_last. Outputs are sampled on the falling edge; inputs change 1
// time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

  localparam int DSIZE     = 8;
  localparam int BURST_LEN = 4;
`ifdef FIFO_READER_STATS_EN
  localparam logic [15:0] STALL_EXP = 16'd20;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
`endif

  logic             clk = 1'b0;
  logic             rst_b;
  logic [DSIZE-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic             flush;
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic [15:0]      stall_cycles;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DSIZE     (DSIZE),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .flush        (flush),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .stall_cycles (stall_cycles)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] exp_q[$];
  int               exp_beat;

  logic             s_valid, s_last, s_rd, s_acc;
  logic [DSIZE-1:0] s_data;
  logic [15:0]      s_stall;

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push_word(input logic [DSIZE-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    refresh();
  endtask

  task automatic sample();
    @(negedge clk);
    s_valid = m_valid;
    s_data  = m_data;
    s_last  = m_last;
    s_rd    = fifo_rd_en;
    s_stall = stall_cycles;
    s_acc   = m_valid & m_ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (s_rd && fifo_q.size() > 0) fifo_q.delete(0);
    refresh();
  endtask

  function automatic void advance_beat();
    exp_beat = (exp_beat == BURST_LEN - 1) ? 0 : exp_beat + 1;
  endfunction

  function automatic logic exp_last();
    return (exp_beat == BURST_LEN - 1);
  endfunction

  // One-cycle flush used between scenarios when nothing is held.
  task automatic do_flush();
    flush = 1'b1;
    sample();
    step();
    flush = 1'b0;
    exp_beat = 0;
  endtask

  task automatic test_reset();
    rst_b    = 1'b0;
    flush    = 1'b0;
    m_ready  = 1'b0;
    exp_beat = 0;
    fifo_q.delete();
    exp_q.delete();
    refresh();
    repeat (2) @(posedge clk);
    sample();
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_m_valid got %0b expected 0", s_valid); end
    n_checks++; if (s_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_m_data got %h expected 00", s_data); end
    n_checks++; if (s_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_m_last got %0b expected 0", s_last); end
    n_checks++; if (s_stall !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_stall got %0d expected 0", s_stall); end
    // A non-empty FIFO must not be popped while reset is held.
    fifo_q.push_back(8'h5A);
    refresh();
    #1;
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_en got %0b expected 0", fifo_rd_en); end
    fifo_q.delete();
    refresh();
    @(posedge clk);
    #1;
    rst_b = 1'b1;
  endtask

  task automatic test_basic();
    logic [DSIZE-1:0] w;
    m_ready = 1'b1;
    push_word(8'hA1);
    push_word(8'hA2);
    push_word(8'hA3);
    for (int c = 0; c < 5; c++) begin
      sample();
      n_checks++; if (s_rd !== 1'(c < 3)) begin n_fail++; $display("[TB] FAIL basic_rd_en c=%0d got %0b expected %0b", c, s_rd, c < 3); end
      n_checks++; if (s_valid !== 1'(c >= 1 && c <= 3)) begin n_fail++; $display("[TB] FAIL basic_valid c=%0d got %0b expected %0b", c, s_valid, (c >= 1 && c <= 3)); end
      if (c >= 1 && c <= 3) begin
        w = 8'hA0 + 8'(c);
        n_checks++; if (s_data !== w) begin n_fail++; $display("[TB] FAIL basic_data c=%0d got %h expected %h", c, s_data, w); end
      end
      if (s_acc && exp_q.size() > 0) begin
        w = exp_q.pop_front();
        n_checks++; if (s_data !== w) begin n_fail++; $display("[TB] FAIL basic_order got %h expected %h", s_data, w); end
        n_checks++; if (s_last !== exp_last()) begin n_fail++; $display("[TB] FAIL basic_last got %0b expected %0b", s_last, exp_last()); end
        advance_beat();
      end
      step();
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL basic_remaining got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [DSIZE-1:0] w;
    int pops = 0;
    int cyc  = 0;
    do_flush();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'hB0 + 8'(i));
    for (int c = 0; c < 6; c++) begin
      sample();
      if (s_rd) pops++;
      n_checks++; if (s_rd !== 1'(c < 2)) begin n_fail++; $display("[TB] FAIL bp_rd_en c=%0d got %0b expected %0b", c, s_rd, c < 2); end
      if (c >= 1) begin
        n_checks++; if (s_valid !== 1'b1 || s_data !== 8'hB0) begin n_fail++; $display("[TB] FAIL bp_hold c=%0d got %0b/%h expected 1/b0", c, s_valid, s_data); end
      end
      step();
    end
    n_checks++; if (pops != 2) begin n_fail++; $display("[TB] FAIL bp_pops got %0d expected 2", pops); end
    m_ready = 1'b1;
    while (exp_q.size() > 0 && cyc < 20) begin
      sample();
      n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_gap cyc=%0d got %0b expected 1", cyc, s_valid); end
      if (s_acc) begin
        w = exp_q.pop_front();
        n_checks++; if (s_data !== w) begin n_fail++; $display("[TB] FAIL bp_order got %h expected %h", s_data, w); end
        n_checks++; if (s_last !== exp_last()) begin n_fail++; $display("[TB] FAIL bp_last got %0b expected %0b", s_last, exp_last()); end
        advance_beat();
      end
      step();
      cyc++;
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL bp_timeout got %0d left expected 0", exp_q.size()); end
    sample();
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_drain_valid got %0b expected 0", s_valid); end
    step();
  endtask

  task automatic test_burst();
    logic [DSIZE-1:0] w;
    int idx = 0;
    int cyc = 0;
    do_flush();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_word(8'h10 + 8'(i));
    while (idx < 10 && cyc < 40) begin
      sample();
      if (s_acc) begin
        w = exp_q.pop_front();
        n_checks++; if (s_data !== w) begin n_fail++; $display("[TB] FAIL burst_order got %h expected %h", s_data, w); end
        n_checks++; if (s_last !== 1'(idx == 3 || idx == 7)) begin n_fail++; $display("[TB] FAIL burst_last beat=%0d got %0b expected %0b", idx + 1, s_last, (idx == 3 || idx == 7)); end
        advance_beat();
        idx++;
      end
      step();
      cyc++;
    end
    n_checks++; if (idx != 10) begin n_fail++; $display("[TB] FAIL burst_timeout got %0d beats expected 10", idx); end
    // Counter should sit at 2: two more beats complete the third burst.
    push_word(8'h20);
    push_word(8'h21);
    idx = 0;
    cyc = 0;
    while (idx < 2 && cyc < 10) begin
      sample();
      if (s_acc) begin
        w = exp_q.pop_front();
        n_checks++; if (s_data !== w) begin n_fail++; $display("[TB] FAIL burst_tail_order got %h expected %h", s_data, w); end
        n_checks++; if (s_last !== 1'(idx == 1)) begin n_fail++; $display("[TB] FAIL burst_tail_last idx=%0d got %0b expected %0b", idx, s_last, idx == 1); end
        advance_beat();
        idx++;
      end
      step();
      cyc++;
    end
    n_checks++; if (idx != 2) begin n_fail++; $display("[TB] FAIL burst_tail_timeout got %0d expected 2", idx); end
  endtask

  task automatic test_random();
    logic [DSIZE-1:0] w;
    logic [DSIZE-1:0] prev_data = '0;
    logic             prev_last = 1'b0;
    logic             prev_stall = 1'b0;
    int pushed = 0;
    int got    = 0;
    int cyc    = 0;
    do_flush();
    m_ready = 1'b0;
    while (got < 200 && cyc < 3000) begin
      sample();
      n_checks++; if (s_rd && fifo_q.size() == 0) begin n_fail++; $display("[TB] FAIL rand_rd_when_empty cyc=%0d got 1 expected 0", cyc); end
      if (prev_stall) begin
        n_checks++; if (s_valid !== 1'b1 || s_data !== prev_data || s_last !== prev_last) begin
          n_fail++; $display("[TB] FAIL rand_stable cyc=%0d got %0b/%h/%0b expected 1/%h/%0b", cyc, s_valid, s_data, s_last, prev_data, prev_last);
        end
      end
      if (s_acc) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("[TB] FAIL rand_extra got %h expected no word", s_data);
        end else begin
          w = exp_q.pop_front();
          n_checks++; if (s_data !== w) begin n_fail++; $display("[TB] FAIL rand_order got %h expected %h", s_data, w); end
          n_checks++; if (s_last !== exp_last()) begin n_fail++; $display("[TB] FAIL rand_last got %0b expected %0b", s_last, exp_last()); end
          advance_beat();
          got++;
        end
      end
      prev_stall = s_valid & ~m_ready;
      prev_data  = s_data;
      prev_last  = s_last;
      step();
      cyc++;
      m_ready = 1'($urandom_range(0, 1));
      if (pushed < 200 && $urandom_range(0, 3) != 0) begin
        push_word(8'($urandom_range(0, 255)));
        pushed++;
      end
    end
    n_checks++; if (got != 200) begin n_fail++; $display("[TB] FAIL rand_count got %0d expected 200", got); end
    m_ready = 1'b1;
  endtask

  task automatic test_flush();
    logic [DSIZE-1:0] w;
    int idx = 0;
    int cyc = 0;
    do_flush();
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) push_word(8'hC0 + 8'(i));
    for (int c = 0; c < 3; c++) begin
      sample();
      if (s_acc) begin
        w = exp_q.pop_front();
        n_checks++; if (s_data !== w) begin n_fail++; $display("[TB] FAIL flush_pre_order got %h expected %h", s_data, w); end
        advance_beat();
      end
      step();
    end
    m_ready = 1'b0;
    sample();
    step();
    sample();
    n_checks++; if (s_rd !== 1'b0 || s_data !== 8'hC2) begin n_fail++; $display("[TB] FAIL flush_two_state got %0b/%h expected 0/c2", s_rd, s_data); end
    step();
    // Flush in the full state with an accept in the same cycle.
    flush   = 1'b1;
    m_ready = 1'b1;
    sample();
    n_checks++; if (s_rd !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_rd_en got %0b expected 0", s_rd); end
    n_checks++; if (s_acc !== 1'b1 || s_data !== 8'hC2) begin n_fail++; $display("[TB] FAIL flush_accept got %0b/%h expected 1/c2", s_acc, s_data); end
    void'(exp_q.pop_front());
    step();
    flush = 1'b0;
    void'(exp_q.pop_front());
    exp_beat = 0;
    sample();
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_valid got %0b expected 0", s_valid); end
    n_checks++; if (fifo_q.size() != 2) begin n_fail++; $display("[TB] FAIL flush_fifo_kept got %0d expected 2", fifo_q.size()); end
    step();
    push_word(8'hC6);
    push_word(8'hC7);
    while (idx < 4 && cyc < 20) begin
      sample();
      if (s_acc) begin
        w = exp_q.pop_front();
        n_checks++; if (s_data !== w) begin n_fail++; $display("[TB] FAIL flush_post_order got %h expected %h", s_data, w); end
        n_checks++; if (s_last !== 1'(idx == 3)) begin n_fail++; $display("[TB] FAIL flush_post_last idx=%0d got %0b expected %0b", idx, s_last, idx == 3); end
        advance_beat();
        idx++;
      end
      step();
      cyc++;
    end
    n_checks++; if (idx != 4) begin n_fail++; $display("[TB] FAIL flush_post_timeout got %0d expected 4", idx); end
  endtask

  task automatic test_stats();
    do_flush();
    m_ready = 1'b0;
    push_word(8'hD0);
    sample();
    step();
    sample();
    n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stats_valid got %0b expected 1", s_valid); end
    n_checks++; if (s_stall !== 16'd0) begin n_fail++; $display("[TB] FAIL stats_start got %0d expected 0", s_stall); end
    step();
    repeat (19) begin
      sample();
      step();
    end
    sample();
    n_checks++; if (s_stall !== STALL_EXP) begin n_fail++; $display("[TB] FAIL stats_count got %0d expected %0d", s_stall, STALL_EXP); end
    step();
    flush = 1'b1;
    sample();
    step();
    flush = 1'b0;
    exp_q.delete();
    exp_beat = 0;
    sample();
    n_checks++; if (s_stall !== 16'd0) begin n_fail++; $display("[TB] FAIL stats_flush got %0d expected 0", s_stall); end
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stats_flush_valid got %0b expected 0", s_valid); end
    step();
  endtask

  task automatic test_async_reset();
    m_ready = 1'b1;
    push_word(8'hE0);
    push_word(8'hE1);
    push_word(8'hE2);
    sample();
    step();
    m_ready = 1'b0;
    @(negedge clk);
    #2;
    n_checks++; if (fifo_rd_en !== 1'b1 || m_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL areset_pre got %0b/%0b expected 1/1", fifo_rd_en, m_valid); end
    rst_b = 1'b0;
    #1;
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_rd_en got %0b expected 0", fifo_rd_en); end
    n_checks++; if (m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0) begin n_fail++; $display("[TB] FAIL areset_outputs got %0b/%h/%0b expected 0/00/0", m_valid, m_data, m_last); end
    fifo_q.delete();
    exp_q.delete();
    refresh();
    exp_beat = 0;
    s_rd = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_burst();
    test_random();
    test_flush();
    test_stats();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
